lif_spike_gen: RTL
==================

Name: lif_spike_gen

Overview:
- Fire stage directly downstream of the per-neuron membrane accumulator. Samples the accumulator's vmem once per timestep and compares it with a threshold.
- On a fire it emits a one-cycle reset pulse back to the accumulator, holds integration off for a programmable refractory window, and queues a spike event (neuron id + timestep) on a valid/ready stream to the spike encoder.

Parameters:
- VMEM_W, 16, membrane/threshold width (matches accumulator)
- REF_W, 4, refractory length counter width
- TS_W, 8, timestep counter width
- ID_W, 4, neuron id width
- NEURON_ID, 0, constant id stamped into events

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active-low
- ts_clear  in  1  start of new inference; clears timestep/refractory state
- step_valid  in  1  accumulation for the current timestep is complete; vmem is settled this cycle
- vmem  in  VMEM_W  accumulator membrane value (unsigned)
- threshold  in  VMEM_W  fire threshold (unsigned); sampled with step_valid
- refrac_len  in  REF_W  refractory length in timesteps; sampled at fire
- reset_scan  out  1  one-cycle pulse zeroing the accumulator
- corr_out  out  VMEM_W  correction term to the accumulator (see Optional Feature)
- integ_hold  out  1  high while refractory; upstream forces fast_sum to 0
- spike_valid  out  1  event available
- spike_ready  in  1  consumer accepts
- spike_id  out  ID_W  = NEURON_ID
- spike_ts  out  TS_W  timestep of the fire
- ovf_err  out  1  sticky: an event was dropped because the queue was full

Behaviour:
- Reset (rst_n low, async) forces: FSM=INTEG, ts=0, refractory count=0, queue empty; all outputs 0.
- FSM has two states:
  - INTEG: on step_valid, fire = (vmem >= threshold), compared as unsigned.
    - fire with refrac_len>0 → REFRAC, cnt=refrac_len.
    - fire with refrac_len=0 → stay in INTEG.
    - no fire → stay in INTEG.
  - REFRAC: integ_hold=1; vmem is ignored. Each step_valid decrements cnt; at cnt reaching 0 → INTEG (registered, so integ_hold falls the cycle after the last refractory step).
- Timestep counter ts increments on every step_valid, in any state, and wraps modulo 2^TS_W.
- Fire latency: step_valid+fire at cycle T → reset_scan=1 during T+1 only. The event {NEURON_ID, ts-before-increment} is written to the queue at T+1. spike_valid rises at T+1 if the queue was empty.
- threshold=0: every non-refractory step fires.
- Queue: 2-entry FIFO, first-in first-out.
  - A pop happens when spike_valid && spike_ready.
  - Push and pop in the same cycle on a full queue are both accepted.
  - Push on full without a pop: the event is dropped; ovf_err is set; reset_scan still pulses.
- ts_clear:
  - Sets ts=0 and FSM=INTEG, clears cnt, and pulses reset_scan in the next cycle.
  - Queue contents are kept; ovf_err is cleared.
  - ts_clear with step_valid in the same cycle: ts_clear wins and the step is ignored (no fire, no increment).
- step_valid pulses are never closer than 2 cycles apart (upstream guarantee). Back-to-back steps are undefined.

Optional Feature:
- Macro LIF_SUBRESET_EN.
- Defined: subtractive reset. On a fire, reset_scan stays 0 and corr_out=threshold (value sampled at T) for exactly cycle T+1; otherwise 0. ts_clear still uses reset_scan.
- Undefined: reset-to-zero as above; corr_out tied to 0.

Decomposition:
- lif_pkg: FSM state enum (INTEG, REFRAC) and spike event struct {id, ts}; shared with the accumulator and the encoder.
- Sub-module spike_evt_fifo: parameterized-width 2-entry FIFO with push/pop/full/empty; lif_spike_gen instantiates it.

Test Plan:
- vmem=100, threshold=100, refrac_len=2, step at ts=5 → reset_scan high exactly 1 cycle; event {id=0, ts=5}; integ_hold high across the next 2 steps; vmem=500 during those steps → no fire.
- threshold=0, refrac_len=0, 4 steps, spike_ready=1 → 4 events with ts 0..3; integ_hold never asserted.
- spike_ready=0, 3 fires → first two queued, third dropped; ovf_err=1; release ready → exactly 2 events, in order.
- 256 steps at TS_W=8, vmem below threshold, then a fire → event ts=0 (wrap).
- ts_clear coincident with step_valid and vmem≥threshold → no event; ts=0; reset_scan pulses once; state INTEG.
- LIF_SUBRESET_EN, threshold=40, fire → reset_scan stays 0; corr_out=40 for one cycle only; async rst_n mid-REFRAC → all outputs 0 immediately.

Source files
------------

// File: rtl/lif_pkg.sv
// Shared types for the LIF neuron pipeline (accumulator, fire stage, encoder).
package lif_pkg;

  typedef enum logic {
    INTEG  = 1'b0,
    REFRAC = 1'b1
  } lif_state_e;

  localparam int unsigned LIF_ID_W = 4;
  localparam int unsigned LIF_TS_W = 8;

  typedef struct packed {
    logic [LIF_ID_W-1:0] id;
    logic [LIF_TS_W-1:0] ts;
  } spike_evt_t;

  function automatic spike_evt_t make_evt(input logic [LIF_ID_W-1:0] id,
                                          input logic [LIF_TS_W-1:0] ts);
    spike_evt_t e;
    e.id = id;
    e.ts = ts;
    return e;
  endfunction

endpackage

// File: rtl/spike_evt_fifo.sv
// Two-entry first-in first-out buffer for spike events.
// A push on a full queue is accepted only when a pop happens in the same cycle.
module spike_evt_fifo
  import lif_pkg::*;
#(
  parameter int unsigned W = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic [1:0]   count;
  logic         do_pop;
  logic         do_push;

  assign full     = (count == 2'd2);
  assign empty    = (count == 2'd0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  // Storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/lif_spike_gen.sv
// LIF fire stage: threshold compare once per timestep, accumulator reset pulse,
// refractory hold and spike-event queueing.
// Optional macro LIF_SUBRESET_EN selects subtractive reset (corr_out = threshold
// on a fire instead of a reset_scan pulse).
module lif_spike_gen
  import lif_pkg::*;
#(
  parameter int unsigned VMEM_W    = 16,
  parameter int unsigned REF_W     = 4,
  parameter int unsigned TS_W      = 8,
  parameter int unsigned ID_W      = 4,
  parameter int unsigned NEURON_ID = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ts_clear,
  input  logic              step_valid,
  input  logic [VMEM_W-1:0] vmem,
  input  logic [VMEM_W-1:0] threshold,
  input  logic [REF_W-1:0]  refrac_len,
  output logic              reset_scan,
  output logic [VMEM_W-1:0] corr_out,
  output logic              integ_hold,
  output logic              spike_valid,
  input  logic              spike_ready,
  output logic [ID_W-1:0]   spike_id,
  output logic [TS_W-1:0]   spike_ts,
  output logic              ovf_err
);

  localparam int unsigned EVT_W = ID_W + TS_W;

  lif_state_e        state;
  logic [REF_W-1:0]  cnt;
  logic [TS_W-1:0]   ts;
  logic              fire;
  logic              pop;
  logic              full;
  logic              empty;
  logic              drop;
  logic [EVT_W-1:0]  evt_in;
  logic [EVT_W-1:0]  evt_head;

  // The event is pushed in the fire cycle so it is visible on the stream
  // one cycle later, aligned with the reset pulse.
  assign fire        = step_valid && !ts_clear && (state == INTEG) && (vmem >= threshold);
  assign evt_in      = {ID_W'(NEURON_ID), ts};
  assign spike_valid = !empty;
  assign pop         = spike_valid && spike_ready;
  assign drop        = fire && full && !pop;
  assign integ_hold  = (state == REFRAC);
  assign spike_id    = evt_head[EVT_W-1:TS_W];
  assign spike_ts    = evt_head[TS_W-1:0];

  spike_evt_fifo #(
    .W (EVT_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fire),
    .push_data (evt_in),
    .pop       (pop),
    .pop_data  (evt_head),
    .full      (full),
    .empty     (empty)
  );

  // Integrate/refractory FSM with timestep counter, reset pulse and overflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= INTEG;
      cnt        <= '0;
      ts         <= '0;
      reset_scan <= 1'b0;
      ovf_err    <= 1'b0;
    end else begin
      reset_scan <= 1'b0;
      if (ts_clear) begin
        state      <= INTEG;
        cnt        <= '0;
        ts         <= '0;
        reset_scan <= 1'b1;
        ovf_err    <= 1'b0;
      end else begin
        if (drop) begin
          ovf_err <= 1'b1;
        end
`ifndef LIF_SUBRESET_EN
        if (fire) begin
          reset_scan <= 1'b1;
        end
`endif
        if (step_valid) begin
          ts <= ts + TS_W'(1);
          case (state)
            INTEG: begin
              if (fire && (refrac_len != '0)) begin
                state <= REFRAC;
                cnt   <= refrac_len;
              end
            end
            REFRAC: begin
              cnt <= cnt - REF_W'(1);
              if (cnt == REF_W'(1)) begin
                state <= INTEG;
              end
            end
            default: state <= INTEG;
          endcase
        end
      end
    end
  end

`ifdef LIF_SUBRESET_EN
  // Subtractive reset: present the sampled threshold for one cycle after a fire
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corr_out <= '0;
    end else begin
      corr_out <= fire ? threshold : '0;
    end
  end
`else
  assign corr_out = '0;
`endif

endmodule
